sipo_shift_reg_rx: RTL and testbench
====================================

Name: sipo_shift_reg_rx

Overview:
UART receive-side serial-in/parallel-out shifter. It is the counterpart of the Tx PISO shift register and sits between the line input pin and the Rx data/status interface. It oversamples the line, detects and validates start bits, samples data bits LSB-first at mid-bit, and checks optional parity and the stop bit. Each received character is presented with a one-cycle valid strobe and error flags.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per bit period; must be a power of two, minimum 8.
SYNC_STAGES, 2, flops in the input synchroniser; minimum 2.

Ports:
baud_clk  input  1  oversampling clock, OVERSAMPLE x bit rate; all logic on posedge
resetn  input  1  reset, asynchronous, active-low
serial_data_in  input  1  asynchronous UART line; idle high
data_length  input  4  data bits per frame, 1..8; 0 or >8 treated as 8
parity_type  input  2  0=even, 1=odd, 2=none, 3=even (reserved, same as 0)
data_out  output  8  received character, right-aligned; unused upper bits are 0
data_valid  output  1  one-cycle strobe; data_out and error flags valid with it
parity_error  output  1  expected parity did not match the sampled parity bit
framing_error  output  1  stop bit was sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE; synchroniser flops=1; sample counter=0; bit counter=0; shift register=0; data_out=0; data_valid=0; parity_error=0; framing_error=0; busy=0.
- All line decisions use the synchronised input rx_s only, which is SYNC_STAGES cycles behind the pin.
- Sample counter width is log2(OVERSAMPLE). The bit counter is 4 bits.
- IDLE: rx_s==0 -> START with counter=0. Latch data_length (after clamping) and parity_type at this point; they are held for the whole frame.
- START: increment the counter. At count OVERSAMPLE/2-1 (mid start bit), check rx_s:
  - rx_s==0 -> DATA, counter=0, bit counter=0.
  - rx_s==1 -> false start (glitch); return to IDLE with no strobe and no flag change.
- DATA: at count OVERSAMPLE-1 (mid-bit), shift rx_s into bit 7 of the shift register (right shift), increment the bit counter, and wrap the counter to 0.
  - When the sampled bit is number len-1: go to PARITY if parity_type!=2, else STOP.
- PARITY: at mid-bit, capture the parity bit.
  - Even: expected = XOR of the received data bits.
  - Odd: expected = NOT of that XOR.
  - Go to STOP.
- STOP: at mid-bit, sample rx_s.
  - Form data_out = shift register >> (8-len).
  - Set parity_error (0 when no parity).
  - Set framing_error = ~rx_s.
  - Assert data_valid for exactly the next cycle.
  - rx_s==1 -> IDLE immediately, at mid stop bit, so the receiver can resync to a back-to-back start edge.
  - rx_s==0 -> BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one framing_error frame, not a stream of them.
- Latency: data_valid rises on the first posedge after the stop-bit sample edge.
- data_out, parity_error and framing_error hold their values until the next data_valid.
- data_length or parity_type changing mid-frame has no effect until the next start.
- Reset mid-frame aborts the frame with no strobe. After release the block returns to IDLE and needs a fresh falling edge. A line that is still low at release is handled as a start candidate and validated by the mid-bit check.
- The state encoding has 6 values in 3 bits. Unused encodings -> IDLE.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity constants PARITY_EVEN=0, PARITY_ODD=1, PARITY_NONE=2;
  - MAX_DATA_BITS=8.
  The Tx shifter shares the same package.
- One sub-module, sync_ff: a SYNC_STAGES-deep synchroniser with an async reset value of 1.

Test Plan:
- 8N1, 0xA5, clean 16x timing -> one data_valid, data_out=0xA5, parity_error=0, framing_error=0. Strobe appears 1 cycle after the stop mid-sample.
- 7E1, 0x53 with the correct even parity bit 0 -> data_out=0x53, parity_error=0. Repeat with the parity bit flipped to 1 -> parity_error=1, data_out still 0x53.
- 5O1, 0x1F, parity bit 0 (correct odd parity) -> data_out=0x1F with bits 7:5=0, parity_error=0.
- Line low for 3 cycles then back high -> no state beyond START, no data_valid, busy returns to 0 within OVERSAMPLE/2+SYNC_STAGES cycles.
- 8N1, 0x00 with the stop bit held low for 40 bit-times, then high, then a 0x3C frame -> first strobe shows data_out=0x00, framing_error=1. No further strobes during the low period. Second strobe shows 0x3C with framing_error=0.
- resetn pulsed low during data bit 4 of a frame -> all outputs 0 immediately with no strobe. A following 0x81 8N1 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART Rx/Tx shifter types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic [1:0] PARITY_EVEN = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_NONE = 2'd2;

  localparam int MAX_DATA_BITS = 8;

  // Out-of-range lengths (0, 9..15) fall back to a full byte.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0 || len > 4'(MAX_DATA_BITS))
      return 4'(MAX_DATA_BITS);
    return len;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser, resets to the idle-high line level
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      sync_q <= '1;
    else
      sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sipo_shift_reg_rx.sv
// rtl/sipo_shift_reg_rx.sv - UART receive oversampling serial-in/parallel-out shifter
module sipo_shift_reg_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       resetn,
  input  logic       serial_data_in,
  input  logic [3:0] data_length,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_MID_BIT   = CW'(OVERSAMPLE - 1);

  logic rx_s;

  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] len_q, len_d;
  logic [1:0] ptype_q, ptype_d;
  logic perr_pend_q, perr_pend_d;
  logic [7:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d;
  logic parity_error_q, parity_error_d;
  logic framing_error_q, framing_error_d;
  logic mid_bit;
  logic exp_parity;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (baud_clk),
    .resetn (resetn),
    .d      (serial_data_in),
    .q      (rx_s)
  );

  assign mid_bit = (cnt_q == CNT_MID_BIT);
  // The shifter is cleared at frame start, so XOR over all 8 bits is the data parity.
  assign exp_parity = (^shift_q) ^ (ptype_q == PARITY_ODD);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CW'(1);
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    len_d           = len_q;
    ptype_d         = ptype_q;
    perr_pend_d     = perr_pend_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          len_d   = clamp_len(data_length);
          ptype_d = parity_type;
        end
      end
      START: begin
        if (cnt_q == CNT_MID_START) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d     = DATA;
            bit_cnt_d   = '0;
            shift_d     = '0;
            perr_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == len_q - 4'd1)
            state_d = (ptype_q == PARITY_NONE) ? STOP : PARITY;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          cnt_d       = '0;
          perr_pend_d = (rx_s != exp_parity);
          state_d     = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          cnt_d           = '0;
          data_out_d      = shift_q >> (4'd8 - len_q);
          parity_error_d  = perr_pend_q;
          framing_error_d = ~rx_s;
          data_valid_d    = 1'b1;
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          state_d         = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s)
          state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      len_q           <= 4'(MAX_DATA_BITS);
      ptype_q         <= PARITY_EVEN;
      perr_pend_q     <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      len_q           <= len_d;
      ptype_q         <= ptype_d;
      perr_pend_q     <= perr_pend_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_shift_reg_rx.sv
// tb/tb_sipo_shift_reg_rx.sv - randomized frame-level bench for sipo_shift_reg_rx
module tb_sipo_shift_reg_rx;

  localparam int OS   = 16;
  localparam int SYNC = 2;
  localparam int HALF = OS / 2;

  logic       baud_clk = 1'b0;
  logic       resetn;
  logic       serial_data_in;
  logic [3:0] data_length;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  sipo_shift_reg_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
    .baud_clk       (baud_clk),
    .resetn         (resetn),
    .serial_data_in (serial_data_in),
    .data_length    (data_length),
    .parity_type    (parity_type),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .busy           (busy)
  );

  always #5 baud_clk = ~baud_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Every strobe must match the oldest outstanding expected character.
  always @(negedge baud_clk) begin
    if (resetn && data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
        check("parity_error", {31'd0, parity_error}, {31'd0, mon_e.pe});
        check("framing_error", {31'd0, framing_error}, {31'd0, mon_e.fe});
        check("strobe_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic drive(input logic v, input int ncyc);
    serial_data_in = v;
    repeat (ncyc) @(posedge baud_clk);
    #1;
  endtask

  // stop_low_bits = 0 gives a good stop bit; otherwise the line stays low that many bit times.
  task automatic send_frame(input logic [7:0] data, input logic [3:0] dl, input logic [1:0] pt,
                            input logic corrupt, input int stop_low_bits, input logic scramble);
    int   len;
    int   nbits;
    logic has_par;
    logic pbit;
    logic [7:0] mask;
    exp_t e;
    len     = (dl == 0 || dl > 8) ? 8 : int'(dl);
    has_par = (pt != 2'd2);
    nbits   = len + (has_par ? 1 : 0);
    mask    = 8'((16'd1 << len) - 16'd1);
    pbit    = logic'($countones(data & mask) % 2) ^ (pt == 2'd1) ^ corrupt;
    e.data  = data & mask;
    e.pe    = corrupt & has_par;
    e.fe    = (stop_low_bits > 0);
    e.at    = cyc + SYNC + 1 + HALF + OS * (nbits + 1);
    exp_q.push_back(e);
    data_length = dl;
    parity_type = pt;
    drive(1'b0, OS);
    if (scramble) begin
      data_length = 4'($urandom);
      parity_type = 2'($urandom);
    end
    for (int i = 0; i < len; i++) drive(data[i], OS);
    if (has_par) drive(pbit, OS);
    if (stop_low_bits == 0) begin
      drive(1'b1, OS);
    end else begin
      drive(1'b0, OS * stop_low_bits);
      check("break_busy", {31'd0, busy}, 32'd1);
      drive(1'b1, 2 * OS);
      check("break_exit_busy", {31'd0, busy}, 32'd0);
    end
    check("strobe_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    resetn         = 1'b0;
    serial_data_in = 1'b1;
    data_length    = 4'd8;
    parity_type    = 2'd2;
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_perr", {31'd0, parity_error}, 32'd0);
    check("rst_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge baud_clk);
    #1;
    resetn = 1'b1;
    drive(1'b1, 2 * OS);

    send_frame(8'hA5, 4'd8, 2'd2, 1'b0, 0, 1'b0);
    send_frame(8'h53, 4'd7, 2'd0, 1'b0, 0, 1'b0);
    send_frame(8'h53, 4'd7, 2'd0, 1'b1, 0, 1'b0);
    send_frame(8'h1F, 4'd5, 2'd1, 1'b0, 0, 1'b0);

    // Short glitch must be rejected at the mid start-bit check.
    drive(1'b0, 3);
    check("glitch_busy_rise", {31'd0, busy}, 32'd1);
    serial_data_in = 1'b1;
    w = 0;
    while (busy && w < HALF + SYNC) begin
      @(posedge baud_clk);
      #1;
      w++;
    end
    check("glitch_busy_clear", {31'd0, busy}, 32'd0);
    drive(1'b1, 2 * OS);

    send_frame(8'h00, 4'd8, 2'd2, 1'b0, 40, 1'b0);
    send_frame(8'h3C, 4'd8, 2'd2, 1'b0, 0, 1'b0);
    send_frame(8'h53, 4'd7, 2'd0, 1'b1, 0, 1'b0);

    // Abort a frame with reset during data bit 4.
    data_length = 4'd8;
    parity_type = 2'd2;
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(i[0], OS);
    drive(1'b1, HALF);
    resetn = 1'b0;
    #1;
    check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
    check("mid_rst_perr", {31'd0, parity_error}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge baud_clk);
    #1;
    resetn = 1'b1;
    drive(1'b1, 2 * OS);
    send_frame(8'h81, 4'd8, 2'd2, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int low_bits;
      low_bits = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      send_frame(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), low_bits, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) drive(1'b1, $urandom_range(1, 2 * OS));
    end

    drive(1'b1, 2 * OS);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
